guess_checker: RTL

- Consumer end of the random-number path. Latches a 10-bit target when the generator presents a fresh value, then scores player guesses taken from the switches.
- Each guess is committed by the submit push-button.
- Reports too low / too high / correct, counts attempts and flags win or loss.
- Drives two 7-segment digits: attempt count and result glyph.

---
 rtl/guess_checker_pkg.sv | 41 ++++
 rtl/guess_checker_button_cond.sv | 60 ++++++
 rtl/guess_checker.sv | 114 +++++++++++
 3 files changed

// File: rtl/guess_checker_pkg.sv
// Shared types, segment glyphs and hex decoder for the guess checker.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
package guess_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WON  = 2'd2,
      ST_LOST = 2'd3
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_L     = 7'h47;
   localparam logic [6:0] SEG_H     = 7'h09;
   localparam logic [6:0] SEG_EQ    = 7'h37;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/guess_checker_button_cond.sv
// Submit button conditioning: 2-flop sync, optional debouncer, rising-edge pulse.
// Debouncer is built only when GUESS_CHECKER_DEBOUNCE_EN is defined.
module button_cond
`ifdef GUESS_CHECKER_DEBOUNCE_EN
   #(parameter int unsigned DEB_CYCLES = 50000)
`endif
   (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic sync1_q, sync2_q, prev_q;
   logic level;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

`ifdef GUESS_CHECKER_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

   logic          deb_q;
   logic [CW-1:0] cnt_q;

   // Level follows the input only after DEB_CYCLES disagreeing cycles in a row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else if (sync2_q == deb_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
         deb_q <= sync2_q;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign level = deb_q;
`else
   assign level = sync2_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_q <= 1'b0;
      else      prev_q <= level;
   end

   assign press = level & ~prev_q;

endmodule

// File: rtl/guess_checker.sv
// Guess checker: latches a target, scores guesses, drives two 7-seg digits.
// Optional submit debouncer: define GUESS_CHECKER_DEBOUNCE_EN.
module guess_checker
   import guess_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int MAX_TRIES  = 10,
   parameter int DEB_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] target,
   input  logic             target_valid,
   input  logic [WIDTH-1:0] guess,
   input  logic             submit,
   output logic             too_low,
   output logic             too_high,
   output logic             correct,
   output logic [3:0]       tries,
   output logic             game_over,
   output logic             win,
   output logic [6:0]       disp_0,
   output logic [6:0]       disp_1
);

   if (MAX_TRIES < 1 || MAX_TRIES > 15 || DEB_CYCLES < 1) begin : g_bad_param
      $error("guess_checker: parameter out of range");
   end

   logic press;

`ifdef GUESS_CHECKER_DEBOUNCE_EN
   button_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
`else
   button_cond u_btn (
`endif
      .clk   (clk),
      .rst   (rst),
      .btn   (submit),
      .press (press)
   );

   state_e           state_d, state_q;
   logic [WIDTH-1:0] tgt_d, tgt_q;
   logic [3:0]       tries_d, tries_q;
   logic             lo_d, lo_q;
   logic             hi_d, hi_q;
   logic             eq_d, eq_q;
   logic [3:0]       tries_inc;

   assign tries_inc = tries_q + 4'd1;

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      tries_d = tries_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      eq_d    = eq_q;
      if (target_valid) begin
         state_d = ST_PLAY;
         tgt_d   = target;
         tries_d = 4'd0;
         lo_d    = 1'b0;
         hi_d    = 1'b0;
         eq_d    = 1'b0;
      end else if (state_q == ST_PLAY && press) begin
         tries_d = tries_inc;
         lo_d    = guess < tgt_q;
         hi_d    = guess > tgt_q;
         eq_d    = guess == tgt_q;
         if (guess == tgt_q)
            state_d = ST_WON;
         else if (tries_inc == 4'(MAX_TRIES))
            state_d = ST_LOST;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
         tries_q <= 4'd0;
         lo_q    <= 1'b0;
         hi_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         tries_q <= tries_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         eq_q    <= eq_d;
      end
   end

   assign too_low   = lo_q;
   assign too_high  = hi_q;
   assign correct   = eq_q;
   assign tries     = tries_q;
   assign game_over = (state_q == ST_WON) || (state_q == ST_LOST);
   assign win       = state_q == ST_WON;
   assign disp_0    = hex7(tries_q);

   // A lost game keeps its last too_low/too_high flag, so the dash wins.
   always_comb begin
      disp_1 = SEG_BLANK;
      if (state_q == ST_LOST) disp_1 = SEG_DASH;
      else if (eq_q)          disp_1 = SEG_EQ;
      else if (lo_q)          disp_1 = SEG_L;
      else if (hi_q)          disp_1 = SEG_H;
   end

endmodule
